// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: funct3 op codes,
// FSM state encoding and the RV32M special-case result constants.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/ex_div_iter.sv
// Restoring radix-2 divider datapath on operand magnitudes; one quotient bit per step.
// Exposes the post-step quotient/remainder so the controller can load them on the final edge.
import muldiv_pkg::*;

module ex_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // The remainder stays below the divisor, so the shifted value needs only one extra bit
    // and a set MSB of the difference means the trial subtraction borrowed.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[XLEN];
        rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for the shared iterative RV32M multiply/divide unit.
// Optional build macro MULDIV_FAST_MUL_EN: MUL family becomes a single-edge combinational product.
import muldiv_pkg::*;

module ex_muldiv_ctrl #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 2
) (
    input  logic            clk_I,
    input  logic            rst,
    input  logic            Req_valid,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Src_A,
    input  logic [XLEN-1:0] Src_B,
    input  logic            Hold,
    output logic            Busy,
    output logic            Res_valid,
    output logic [XLEN-1:0] Result
);

`ifdef MULDIV_FAST_MUL_EN
    localparam int N_MUL = 1;
`else
    localparam int MB    = MUL_BITS_PER_CYCLE;
    localparam int N_MUL = XLEN / MB;
`endif
    localparam int              CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(N_MUL);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [XLEN-1:0]  MIN_NEG = XLEN'(INT_MIN) << (XLEN - 32);
    localparam logic [XLEN-1:0]  Q_ZERO  = {(XLEN/32){DIV_ZERO_Q}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q;
    logic              a_neg_q, b_neg_q;
    logic              a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic              b_zero, sgn_ovf, div_special;
    logic [XLEN-1:0]   special_res;
    logic              accept, div_load, div_step;
    logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod;
    logic              result_ld;
    logic [XLEN-1:0]   result_d;

    // Handshake: EX holds Req_valid until it sees Res_valid; Busy low means EX may advance on
    // the next edge, which happens only in DONE. Hold freezes everything, including DONE.
    assign Busy = Req_valid & (state_q != ST_DONE);

    always_comb begin
        a_neg_in = 1'b0;
        b_neg_in = 1'b0;
        if (Op[2]) begin
            a_neg_in = ~Op[0] & Src_A[XLEN-1];
            b_neg_in = ~Op[0] & Src_B[XLEN-1];
        end else begin
            a_neg_in = ((Op == OP_MULH) || (Op == OP_MULHSU)) & Src_A[XLEN-1];
            b_neg_in = (Op == OP_MULH) & Src_B[XLEN-1];
        end
    end

    assign a_mag_in    = a_neg_in ? -Src_A : Src_A;
    assign b_mag_in    = b_neg_in ? -Src_B : Src_B;
    assign b_zero      = (Src_B == '0);
    assign sgn_ovf     = ~Op[0] & (Src_A == MIN_NEG) & (Src_B == '1);
    assign div_special = b_zero | sgn_ovf;
    assign special_res = b_zero ? (Op[1] ? Src_A : Q_ZERO) : (Op[1] ? '0 : MIN_NEG);

    assign accept   = (state_q == ST_IDLE) & Req_valid & ~Hold;
    assign div_load = accept & Op[2] & ~div_special;
    assign div_step = (state_q == ST_DIV) & Req_valid & ~Hold;

    ex_div_iter #(.XLEN(XLEN)) u_div (
        .clk      (clk_I),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag_in),
        .divisor  (b_mag_in),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    assign quo_fix = (a_neg_q ^ b_neg_q) ? -quo_nxt : quo_nxt;
    assign rem_fix = a_neg_q ? -rem_nxt : rem_nxt;

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0] a_q, b_q;

    assign prod = {{XLEN{a_neg_q}}, a_q} * {{XLEN{b_neg_q}}, b_q};

    always_ff @(posedge clk_I) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept && !Op[2]) begin
            a_q <= Src_A;
            b_q <= Src_B;
        end
    end
`else
    logic [XLEN-1:0]    mcand_q;
    logic [2*XLEN-1:0]  acc_q, acc_step;
    logic [XLEN+MB-1:0] mul_part, mul_sum;

    // Low half of the accumulator holds the unretired multiplier bits; partial sums enter the
    // high half and the whole accumulator shifts right by MB each step.
    always_comb begin
        mul_part = (XLEN+MB)'(mcand_q) * (XLEN+MB)'(acc_q[MB-1:0]);
        mul_sum  = {{MB{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_part;
        acc_step = {mul_sum, acc_q[XLEN-1:MB]};
        prod     = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
    end

    always_ff @(posedge clk_I) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
        end else if (!Hold) begin
            if (accept && !Op[2]) begin
                acc_q   <= {{XLEN{1'b0}}, a_mag_in};
                mcand_q <= b_mag_in;
            end else if (state_q == ST_MUL && Req_valid) begin
                acc_q <= acc_step;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_ld = 1'b0;
        result_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (Req_valid) begin
                    if (!Op[2]) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_MUL;
                    end else if (div_special) begin
                        state_d   = ST_DONE;
                        result_ld = 1'b1;
                        result_d  = special_res;
                    end else begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (!Req_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d   = ST_DONE;
                        result_ld = 1'b1;
                        result_d  = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    end
                end
            end
            ST_DIV: begin
                if (!Req_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d   = ST_DONE;
                        result_ld = 1'b1;
                        result_d  = op_q[1] ? rem_fix : quo_fix;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_I) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            Res_valid <= 1'b0;
            Result    <= '0;
        end else if (!Hold) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            Res_valid <= (state_d == ST_DONE);
            if (result_ld) Result <= result_d;
            if (accept) begin
                op_q    <= Op[1:0];
                a_neg_q <= a_neg_in;
                b_neg_q <= b_neg_in;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: vector table, random ops against a reference model,
// and hand-written Hold / abort / back-to-back / reset sequences.
import muldiv_pkg::*;

module tb_ex_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 17;
`endif
    localparam int DIV_LAT = 33;
    localparam int ABORT_K = (MUL_LAT > 8) ? 8 : 1;

    logic        clk_I;
    logic        rst;
    logic        req_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hold;
    logic        busy;
    logic        res_valid;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    ex_muldiv_ctrl dut (
        .clk_I     (clk_I),
        .rst       (rst),
        .Req_valid (req_valid),
        .Op        (op),
        .Src_A     (src_a),
        .Src_B     (src_b),
        .Hold      (hold),
        .Busy      (busy),
        .Res_valid (res_valid),
        .Result    (result)
    );

    // clock / reset
    initial clk_I = 1'b0;
    always #5 clk_I = ~clk_I;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'b001: begin p = 64'(sa * sb); r = p[63:32]; end
            3'b010: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'b100: r = (b == 0) ? DIV_ZERO_Q : (a == INT_MIN && b == 32'hFFFF_FFFF) ? INT_MIN
                                 : 32'($signed(a) / $signed(b));
            3'b101: r = (b == 0) ? DIV_ZERO_Q : a / b;
            3'b110: r = (b == 0) ? a : (a == INT_MIN && b == 32'hFFFF_FFFF) ? 32'h0
                                 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int lat_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 0 || (!o[0] && a == INT_MIN && b == 32'hFFFF_FFFF)) return 1;
        return DIV_LAT;
    endfunction

    // driver: called just after a rising edge; cycle 0 is the cycle Req_valid is first high
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit keep);
        int          k;
        int          busy_bad;
        bit          got;
        logic [31:0] exp_v;
        exp_q.push_back(e);
        req_valid = 1'b1;
        op        = o;
        src_a     = a;
        src_b     = b;
        k         = 0;
        busy_bad  = 0;
        got       = 1'b0;
        while (!got && k <= 100) begin
            @(negedge clk_I);
            if (res_valid) begin
                got = 1'b1;
                check("latency", 32'(k), 32'(lat));
                check("busy_in_done", 32'(busy), 32'd0);
                exp_v = exp_q.pop_front();
                check("result", result, exp_v);
                last_exp = exp_v;
            end else begin
                if (!busy) busy_bad++;
                k++;
            end
            @(posedge clk_I);
            #1;
        end
        check("res_valid_seen", 32'(got), 32'd1);
        if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
        check("busy_while_pending", 32'(busy_bad), 32'd0);
        if (!keep) begin
            req_valid = 1'b0;
            @(negedge clk_I);
            check("res_valid_one_cycle", 32'(res_valid), 32'd0);
            @(posedge clk_I);
            #1;
        end
    endtask

    initial begin
        int          first_rise, last_high, rises, bad, rv_seen;
        logic        prev_rv;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b, exp_v;

        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
        vecs[6]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
        vecs[7]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT};
        vecs[8]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT};
        vecs[9]  = '{OP_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[10] = '{OP_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1};
        vecs[11] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[12] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[13] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, DIV_LAT};
        vecs[14] = '{OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
        vecs[15] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT};
        vecs[16] = '{OP_DIV,    32'h8000_0000,  32'd2,         32'hC000_0000, DIV_LAT};
        vecs[17] = '{OP_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT};

        rst       = 1'b1;
        req_valid = 1'b0;
        op        = '0;
        src_a     = '0;
        src_b     = '0;
        hold      = 1'b0;
        repeat (3) @(posedge clk_I);
        #1;
        rst = 1'b0;
        @(negedge clk_I);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk_I);
        #1;

        for (int i = 0; i < 18; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 7) == 0) ? INT_MIN : $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 15);
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            do_op(r_op, r_a, r_b, model(r_op, r_a, r_b), lat_model(r_op, r_a, r_b), 1'b0);
        end

        // Hold for 5 cycles mid-DIV and 2 cycles in DONE
        exp_q.push_back(32'hFFFF_FFFD);
        op         = OP_DIV;
        src_a      = 32'hFFFF_FFF9;
        src_b      = 32'd2;
        first_rise = -1;
        last_high  = -1;
        rises      = 0;
        bad        = 0;
        prev_rv    = 1'b0;
        for (int k = 0; k < 46; k++) begin
            req_valid = (k <= 40);
            hold      = (k >= 10 && k < 15) || k == 38 || k == 39;
            @(negedge clk_I);
            if (res_valid && !prev_rv) begin
                rises++;
                if (first_rise < 0) begin
                    first_rise = k;
                    exp_v = exp_q.pop_front();
                    check("hold_result", result, exp_v);
                end
            end
            if (res_valid) last_high = k;
            if (k >= 10 && k < 15 && (res_valid || result !== last_exp)) bad++;
            if ((k == 39 || k == 40) && result !== 32'hFFFF_FFFD) bad++;
            prev_rv = res_valid;
            @(posedge clk_I);
            #1;
        end
        hold     = 1'b0;
        last_exp = 32'hFFFF_FFFD;
        check("hold_first_rise", 32'(first_rise), 32'd38);
        check("hold_last_high", 32'(last_high), 32'd40);
        check("hold_single_pulse", 32'(rises), 32'd1);
        check("hold_frozen", 32'(bad), 32'd0);

        // abort: Req_valid dropped during MUL
        op      = OP_MUL;
        src_a   = 32'd1234;
        src_b   = 32'd5;
        rv_seen = 0;
        bad     = 0;
        for (int k = 0; k < 28; k++) begin
            req_valid = (k < ABORT_K);
            @(negedge clk_I);
            if (res_valid) rv_seen++;
            if (result !== last_exp) bad++;
            @(posedge clk_I);
            #1;
        end
        check("abort_no_res_valid", 32'(rv_seen), 32'd0);
        check("abort_result_kept", 32'(bad), 32'd0);
        do_op(OP_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT, 1'b0);

        // back-to-back: Req_valid stays high through DONE
        do_op(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, MUL_LAT, 1'b1);
        do_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 1'b0);

        // reset together with Hold in the middle of a DIV
        req_valid = 1'b1;
        op        = OP_DIV;
        src_a     = 32'd1000;
        src_b     = 32'd7;
        repeat (10) @(posedge clk_I);
        #1;
        rst       = 1'b1;
        hold      = 1'b1;
        req_valid = 1'b0;
        @(posedge clk_I);
        #1;
        rst  = 1'b0;
        hold = 1'b0;
        @(negedge clk_I);
        check("rst_mid_div_res_valid", 32'(res_valid), 32'd0);
        check("rst_mid_div_result", result, 32'd0);
        check("rst_mid_div_busy", 32'(busy), 32'd0);
        @(posedge clk_I);
        #1;
        do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
